// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue/writeback stage wrapped around an external 12-bit combinational ALU.
//   Takes one single-operand instruction at a time over a valid/ready handshake.
//   It owns the accumulator (AC) and drives the ALU with a=AC, b=operand and
//   selectOp=op. It then writes the ALU result back into AC.
//   Each op takes three cycles: IDLE (accept) -> EXEC (ALU active, AC write) ->
//   DONE (completion pulse). That gives a throughput of one op per 3 cycles.
//
// Optional build macro:
//   ALU_FLAGS_EN  adds zero_flag/neg_flag outputs. They are registered with AC
//                 and reset to zero_flag=1, neg_flag=0.
//
// Ports:
//   clk          rising-edge clock
//   rstN         asynchronous active-low reset
//   req_valid    request present
//   req_ready    request accepted at this edge if req_valid (state decode only)
//   req_op       0 clr, 1 pass, 2 add, 3 sub, 4 mul, 5 inc, 6 idle, 7 illegal
//   req_operand  operand b
//   alu_a        ALU a, always AC
//   alu_b        ALU b, operand registered at accept
//   alu_op       ALU selectOp; the op register in EXEC, idle (6) otherwise
//   alu_result   ALU dataOut (combinational from alu_a/alu_b/alu_op)
//   acc          current AC
//   done         one-cycle completion pulse
//   err          one-cycle pulse when an illegal op (7) completes
//   ops_count    completed-operation count, wraps
//   zero_flag    (ALU_FLAGS_EN) AC == 0
//   neg_flag     (ALU_FLAGS_EN) AC sign bit
module alu_op_sequencer #(
  parameter int WIDTH     = 12,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [WIDTH-1:0]     req_operand,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  output logic [WIDTH-1:0]     acc,
  output logic                 done,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] ops_count
`ifdef ALU_FLAGS_EN
  ,
  output logic                 zero_flag,
  output logic                 neg_flag
`endif
);

  localparam logic [2:0] OP_INC     = 3'd5;
  localparam logic [2:0] OP_IDLE    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] acc_q;
  logic             accept;
  logic             acc_we;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs. Nothing here depends on req_*, except
  // the accept strobe, so req_ready has no combinational path from the request.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    alu_op    = OP_IDLE;
    done      = 1'b0;
    err       = 1'b0;
    accept    = 1'b0;
    acc_we    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_op    = op_reg;
        // idle and illegal ops leave AC untouched
        acc_we    = (op_reg <= OP_INC);
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        err       = (op_reg == OP_ILLEGAL);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture. Fields are sampled only at the accept edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      op_reg <= OP_IDLE;
      alu_b  <= '0;
    end else if (accept) begin
      op_reg <= req_op;
      alu_b  <= req_operand;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator writeback. alu_result is valid within the EXEC cycle because
  // the ALU is purely combinational.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)       acc_q <= '0;
    else if (acc_we) acc_q <= alu_result;
  end

  assign acc   = acc_q;
  assign alu_a = acc_q;

  // Completed-op counter: bumps on the EXEC->DONE transition, wraps naturally.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                ops_count <= '0;
    else if (state == S_EXEC) ops_count <= ops_count + 1'b1;
  end

`ifdef ALU_FLAGS_EN
  // Flags are computed from the value being written, so they stay in step
  // with AC.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      zero_flag <= 1'b1;
      neg_flag  <= 1'b0;
    end else if (acc_we) begin
      zero_flag <= (alu_result == '0);
      neg_flag  <= alu_result[WIDTH-1];
    end
  end
`endif

endmodule
